// File: rtl/mcu_read_sequencer.sv
// mcu_read_sequencer
// Reads the RGB565 frame buffer in JPEG 8x8 MCU order (blocks left-to-right,
// top-to-bottom, raster order inside a block), one address per cycle, and
// realigns the returned pixels with their block-local (x,y) and block tags.
// Each block is only started once the downstream MCU stage reports ready.
module mcu_read_sequencer #(
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 180,
    parameter int READ_LATENCY = 2,
    parameter int PIX_WIDTH    = 16,
    localparam int ADDR_W      = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int BCOLS       = IMG_WIDTH / 8,
    localparam int BROWS       = (IMG_HEIGHT + 7) / 8,
    localparam int BC_W        = $clog2(BCOLS),
    localparam int BR_W        = $clog2(BROWS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 mcu_ready_in,
    input  logic [PIX_WIDTH-1:0] pixel_in,
    output logic [ADDR_W-1:0]    addr_out,
    output logic                 addr_valid_out,
    output logic [PIX_WIDTH-1:0] pixel_out,
    output logic                 pixel_valid_out,
    output logic [2:0]           x_out,
    output logic [2:0]           y_out,
    output logic [BC_W-1:0]      block_col_out,
    output logic [BR_W-1:0]      block_row_out,
    output logic                 block_start_out,
    output logic                 block_done_out,
    output logic                 frame_done_out,
    output logic                 busy_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN} state_t;

    // Tag that follows each read request until its pixel comes back.
    typedef struct packed {
        logic            valid;
        logic [2:0]      x;
        logic [2:0]      y;
        logic [BC_W-1:0] bc;
        logic [BR_W-1:0] br;
    } tag_t;

    // DRAIN counts up to READ_LATENCY+1, i.e. until the last pixel is on the output.
    localparam int DR_W = $clog2(READ_LATENCY + 2);

    state_t               state_q, state_d;
    logic [BC_W-1:0]      blk_col_q, blk_col_d;
    logic [BR_W-1:0]      blk_row_q, blk_row_d;
    logic [5:0]           pix_q, pix_d;
    logic [DR_W-1:0]      drain_q, drain_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    tag_t                 issue_tag_q, issue_tag_d;
    tag_t                 pipe_q [READ_LATENCY];
    tag_t                 pipe_d [READ_LATENCY];
    tag_t                 out_tag_q, out_tag_d;
    logic [PIX_WIDTH-1:0] pixel_q, pixel_d;
    logic [ADDR_W-1:0]    row_a;
    logic [ADDR_W-1:0]    addr_calc;

    // Address of the pixel at counter pix_q inside the current block, with bottom-edge row clamp.
    always_comb begin
        // NOTE: blocking assignments in combinational logic: row_a is clamped and then read again in the same pass.
        row_a = ADDR_W'({blk_row_q, 3'b000}) + ADDR_W'(pix_q[5:3]);
        if (row_a > ADDR_W'(IMG_HEIGHT - 1)) begin
            row_a = ADDR_W'(IMG_HEIGHT - 1);
        end
        addr_calc = row_a * ADDR_W'(IMG_WIDTH) + ADDR_W'({blk_col_q, 3'b000}) + ADDR_W'(pix_q[2:0]);
    end

    // Next-state logic: block walk, 64-address issue burst, drain and frame completion.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        blk_col_d    = blk_col_q;
        blk_row_d    = blk_row_q;
        pix_d        = pix_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        addr_d       = addr_q;
        issue_tag_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d   = S_WAIT;
                    busy_d    = 1'b1;
                    blk_col_d = '0;
                    blk_row_d = '0;
                end
            end
            S_WAIT: begin
                if (mcu_ready_in) begin
                    state_d = S_ISSUE;
                    pix_d   = '0;
                end
            end
            S_ISSUE: begin
                addr_d            = addr_calc;
                issue_tag_d.valid = 1'b1;
                issue_tag_d.x     = pix_q[2:0];
                issue_tag_d.y     = pix_q[5:3];
                issue_tag_d.bc    = blk_col_q;
                issue_tag_d.br    = blk_row_q;
                pix_d             = pix_q + 6'd1;
                if (pix_q == 6'd63) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DR_W'(1);
                if (drain_q == DR_W'(READ_LATENCY + 1)) begin
                    if (blk_col_q == BC_W'(BCOLS - 1)) begin
                        blk_col_d = '0;
                        if (blk_row_q == BR_W'(BROWS - 1)) begin
                            blk_row_d    = '0;
                            state_d      = S_IDLE;
                            busy_d       = 1'b0;
                            frame_done_d = 1'b1;
                        end else begin
                            blk_row_d = blk_row_q + BR_W'(1);
                            state_d   = S_WAIT;
                        end
                    end else begin
                        blk_col_d = blk_col_q + BC_W'(1);
                        state_d   = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tag delay line matching the frame-buffer read latency, plus the output pixel register.
    always_comb begin
        pipe_d[0] = issue_tag_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        out_tag_d = pipe_q[READ_LATENCY-1];
        pixel_d   = pipe_q[READ_LATENCY-1].valid ? pixel_in : '0;
    end

    // All state, tag pipeline and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            blk_col_q    <= '0;
            blk_row_q    <= '0;
            pix_q        <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            addr_q       <= '0;
            issue_tag_q  <= '0;
            // NOTE: the tag pipeline is cleared too, otherwise a stale valid could emerge after reset.
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            out_tag_q    <= '0;
            pixel_q      <= '0;
        end else begin
            state_q      <= state_d;
            blk_col_q    <= blk_col_d;
            blk_row_q    <= blk_row_d;
            pix_q        <= pix_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            addr_q       <= addr_d;
            issue_tag_q  <= issue_tag_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            out_tag_q    <= out_tag_d;
            pixel_q      <= pixel_d;
        end
    end

    assign addr_out        = addr_q;
    assign addr_valid_out  = issue_tag_q.valid;
    assign pixel_out       = pixel_q;
    assign pixel_valid_out = out_tag_q.valid;
    assign x_out           = out_tag_q.x;
    assign y_out           = out_tag_q.y;
    assign block_col_out   = out_tag_q.bc;
    assign block_row_out   = out_tag_q.br;
    assign block_start_out = out_tag_q.valid && (out_tag_q.x == 3'd0) && (out_tag_q.y == 3'd0);
    assign block_done_out  = out_tag_q.valid && (out_tag_q.x == 3'd7) && (out_tag_q.y == 3'd7);
    assign frame_done_out  = frame_done_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_mcu_read_sequencer.sv
// Directed bench for mcu_read_sequencer with a latency-2 frame-buffer model.
module tb_mcu_read_sequencer;

    localparam int W     = 320;
    localparam int H     = 180;
    localparam int NPIX  = 58880;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        mcu_ready_in;
    logic [15:0] pixel_in;
    logic [15:0] addr_out;
    logic        addr_valid_out;
    logic [15:0] pixel_out;
    logic        pixel_valid_out;
    logic [2:0]  x_out;
    logic [2:0]  y_out;
    logic [5:0]  block_col_out;
    logic [4:0]  block_row_out;
    logic        block_start_out;
    logic        block_done_out;
    logic        frame_done_out;
    logic        busy_out;

    logic [15:0] rd1 = '0;
    logic [15:0] rd2 = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Monitor state (written only by the monitor process).
    int a_idx = 0, p_idx = 0, a_run = 0, p_run = 0, pv_cnt = 0;
    int bd_cnt = 0, fd_cnt = 0, bd_total = 0, fd_total = 0;
    int a_err = 0, p_err = 0, idle_err = 0, run_err = 0;
    int cyc = 0, last_bd_cyc = 0, fd_cyc = 0;
    int addr_log [NPIX];

    mcu_read_sequencer #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .READ_LATENCY(2),
        .PIX_WIDTH   (16)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .mcu_ready_in   (mcu_ready_in),
        .pixel_in       (pixel_in),
        .addr_out       (addr_out),
        .addr_valid_out (addr_valid_out),
        .pixel_out      (pixel_out),
        .pixel_valid_out(pixel_valid_out),
        .x_out          (x_out),
        .y_out          (y_out),
        .block_col_out  (block_col_out),
        .block_row_out  (block_row_out),
        .block_start_out(block_start_out),
        .block_done_out (block_done_out),
        .frame_done_out (frame_done_out),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    // Frame-buffer contents: a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input int a);
        logic [15:0] v;
        v = a[15:0];
        return {v[7:0], v[15:8]} ^ 16'h5A3C;
    endfunction

    // Expected address of pixel p of block (bc, br), bottom rows clamped.
    function automatic int model_addr(input int bc, input int br, input int p);
        int row;
        row = br * 8 + p / 8;
        if (row > H - 1) row = H - 1;
        return row * W + bc * 8 + p % 8;
    endfunction

    // Two-cycle read latency from addr_out to pixel_in.
    always @(posedge clk) begin
        rd1 <= mem_word(int'(addr_out));
        rd2 <= rd1;
    end
    assign pixel_in = rd2;

    // Stream monitor: logs addresses, scores the pixel stream against the model.
    always @(negedge clk) begin
        int blk, p;
        cyc++;
        if (rst_in) begin
            a_idx = 0; p_idx = 0; a_run = 0; p_run = 0; pv_cnt = 0; bd_cnt = 0; fd_cnt = 0;
        end else begin
            if (addr_valid_out) begin
                blk = (a_idx % NPIX) / 64;
                p   = a_idx % 64;
                addr_log[a_idx % NPIX] = int'(addr_out);
                if (int'(addr_out) != model_addr(blk % 40, blk / 40, p)) a_err++;
                a_idx++;
                a_run++;
            end else if (a_run != 0) begin
                if (a_run != 64) run_err++;
                a_run = 0;
            end
            if (pixel_valid_out) begin
                blk = (p_idx % NPIX) / 64;
                p   = p_idx % 64;
                if (x_out !== 3'(p % 8) || y_out !== 3'(p / 8) ||
                    block_col_out !== 6'(blk % 40) || block_row_out !== 5'(blk / 40)) p_err++;
                if (pixel_out !== mem_word(model_addr(blk % 40, blk / 40, p))) p_err++;
                if (block_start_out !== (p == 0) || block_done_out !== (p == 63)) p_err++;
                p_idx++;
                pv_cnt++;
                p_run++;
            end else begin
                if (pixel_out !== 16'd0 || block_start_out || block_done_out) idle_err++;
                if (p_run != 0) begin
                    if (p_run != 64) run_err++;
                    p_run = 0;
                end
            end
            if (block_done_out) begin
                bd_cnt++;
                bd_total++;
                last_bd_cyc = cyc;
            end
            if (frame_done_out) begin
                fd_cnt++;
                fd_total++;
                fd_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step to just after the next falling edge (monitor has already updated).
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_in       = 1'b1;
        start_in     = 1'b0;
        mcu_ready_in = 1'b0;
        repeat (3) sample();
        check("rst_addr_valid", addr_valid_out, 0);
        check("rst_busy", busy_out, 0);
        rst_in = 1'b0;
        sample();
        check("idle_addr_out", addr_out, 0);
        check("idle_pixel_valid", pixel_valid_out, 0);

        // Frame 1: start, block 0 with ready toggling mid-ISSUE.
        start_in     = 1'b1;
        mcu_ready_in = 1'b1;
        sample();
        start_in = 1'b0;
        check("busy_after_start", busy_out, 1);
        n = 0;
        while (!addr_valid_out && n < 10) begin sample(); n++; end
        check("first_addr_valid", addr_valid_out, 1);
        check("first_addr", addr_out, 0);
        n = 0;
        while (!pixel_valid_out && n < 10) begin
            sample();
            n++;
            mcu_ready_in = ~mcu_ready_in;
        end
        check("pixel_latency", n, 3);
        check("first_block_start", block_start_out, 1);
        check("first_tags", {x_out, y_out, block_col_out, block_row_out}, 0);
        check("first_pixel", pixel_out, mem_word(0));
        repeat (20) begin sample(); mcu_ready_in = ~mcu_ready_in; end
        mcu_ready_in = 1'b0;
        n = 0;
        while (!block_done_out && n < 100) begin sample(); n++; end
        check("block0_done", block_done_out, 1);
        check("block0_last_tags", {x_out, y_out}, 6'o77);

        // Stall in WAIT with ready low.
        repeat (10) sample();
        check("stall_addr_count", a_idx, 64);
        check("stall_addr_valid", addr_valid_out, 0);
        check("stall_busy", busy_out, 1);
        check("b0_addr7", addr_log[7], 7);
        check("b0_addr8", addr_log[8], 320);
        check("b0_addr63", addr_log[63], 2247);

        // Ready sampled at the next edge enters ISSUE; first address follows one edge later.
        mcu_ready_in = 1'b1;
        n = 0;
        while (!addr_valid_out && n < 10) begin sample(); n++; end
        check("resume_latency", n, 2);
        check("block1_first_addr", addr_out, 8);
        repeat (5) sample();
        start_in = 1'b1;
        sample();
        start_in = 1'b0;
        repeat (6) begin sample(); mcu_ready_in = ~mcu_ready_in; end
        mcu_ready_in = 1'b1;

        n = 0;
        while (!frame_done_out && n < 70000) begin sample(); n++; end
        check("frame_done_seen", frame_done_out, 1);
        check("busy_fall_with_done", busy_out, 0);
        check("done_after_last_block", fd_cyc - last_bd_cyc, 1);
        check("block_done_count", bd_cnt, 920);
        check("pixel_valid_count", pv_cnt, 58880);
        check("addr_count", a_idx, 58880);
        check("b39_0_first", addr_log[2496], 312);
        check("b39_0_last", addr_log[2559], 2559);
        check("b0_1_first", addr_log[2560], 2560);
        check("b0_22_row0", addr_log[56320], 56320);
        check("b0_22_row1", addr_log[56328], 56640);
        check("b0_22_row2", addr_log[56336], 56960);
        check("b0_22_row3", addr_log[56344], 57280);
        check("b0_22_row4_clamp", addr_log[56352], 57280);
        check("b0_22_last_clamp", addr_log[56383], 57287);
        check("addr_seq_err", a_err, 0);
        check("pixel_seq_err", p_err, 0);
        check("idle_out_err", idle_err, 0);
        check("burst_len_err", run_err, 0);
        sample();
        check("frame_done_pulse", frame_done_out, 0);
        check("frame_done_count", fd_cnt, 1);

        // Frame 2: asynchronous reset at p=30 of block 5.
        rst_in = 1'b1;
        sample();
        sample();
        rst_in = 1'b0;
        sample();
        start_in     = 1'b1;
        mcu_ready_in = 1'b1;
        sample();
        start_in = 1'b0;
        n = 0;
        while (!(addr_valid_out && addr_out == 16'd1006) && n < 600) begin sample(); n++; end
        check("reached_b5_p30", addr_out, 1006);
        #1 rst_in = 1'b1;
        #1;
        check("arst_addr_valid", addr_valid_out, 0);
        check("arst_addr", addr_out, 0);
        check("arst_pixel", {pixel_valid_out, pixel_out}, 0);
        check("arst_tags", {x_out, y_out, block_col_out, block_row_out}, 0);
        check("arst_flags", {block_start_out, block_done_out, frame_done_out, busy_out}, 0);
        sample();
        sample();
        rst_in = 1'b0;
        repeat (100) sample();
        check("abort_block_done_total", bd_total, 925);
        check("abort_frame_done_total", fd_total, 1);
        check("abort_idle_addr", a_idx, 0);

        // Restart after reset begins again at address 0.
        start_in     = 1'b1;
        mcu_ready_in = 1'b1;
        sample();
        start_in = 1'b0;
        n = 0;
        while (!addr_valid_out && n < 10) begin sample(); n++; end
        check("restart_addr_valid", addr_valid_out, 1);
        check("restart_addr", addr_out, 0);
        n = 0;
        while (!pixel_valid_out && n < 10) begin sample(); n++; end
        check("restart_pixel", pixel_out, mem_word(0));
        check("restart_tags", {x_out, y_out, block_col_out, block_row_out}, 0);
        repeat (100) sample();
        check("restart_stream_err", a_err + p_err + idle_err + run_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
